// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared types and constants for the instruction fetch stage.
//            Holds the fetch FSM state encoding, the PC step between words,
//            the ARM PC read offset and the word-alignment mask.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  localparam logic [31:0] PC_STEP        = 32'd4;
  localparam logic [31:0] PC_READ_OFFSET = 32'd8;
  localparam logic [31:0] WORD_MASK      = 32'hFFFF_FFFC;

  // Clears the byte-offset bits so every address issued is word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage. Owns the fetch address, issues word
//            reads over a req/ack handshake, buffers one instruction for
//            decode (valid/ready) and handles branch redirects, including
//            discarding a read that is already in flight.
// Ports    : clock, reset          - clock, async active-high reset
//            imem_req/addr/ack/rdata - instruction memory read port
//            branch_valid/target   - redirect strobe from execute
//            instr/instr_pc/instr_valid/instr_ready - decode handshake
//            pc_regs               - instr_pc + 8, r15 value for the regfile
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc_regs
);

  localparam logic [31:0] C_RESET_ADDR = RESET_PC & WORD_MASK;

  fetch_state_t state_q, state_d;
  logic [31:0]  fetch_addr_q, fetch_addr_d;
  logic [31:0]  redirect_pc_q, redirect_pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         instr_valid_q, instr_valid_d;

  logic [31:0]  w_branch_tgt;

  assign w_branch_tgt = word_align(branch_target);

  always_comb begin
    state_d       = state_q;
    fetch_addr_d  = fetch_addr_q;
    redirect_pc_d = redirect_pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (branch_valid) begin
          fetch_addr_d = w_branch_tgt;
        end
      end

      FETCH: begin
        if (branch_valid) begin
          if (imem_ack) begin
            // Response belongs to the wrong path: drop it, restart at target.
            fetch_addr_d = w_branch_tgt;
          end else begin
            // Request already on the bus; keep its address stable and
            // remember where to go once it completes.
            redirect_pc_d = w_branch_tgt;
            state_d       = DRAIN;
          end
        end else if (imem_ack) begin
          instr_d       = imem_rdata;
          instr_pc_d    = fetch_addr_q;
          instr_valid_d = 1'b1;
          fetch_addr_d  = fetch_addr_q + PC_STEP;
          state_d       = HOLD;
        end
      end

      HOLD: begin
        if (branch_valid) begin
          instr_valid_d = 1'b0;
          fetch_addr_d  = w_branch_tgt;
          state_d       = FETCH;
        end else if (instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = FETCH;
        end
      end

      DRAIN: begin
        if (branch_valid) begin
          redirect_pc_d = w_branch_tgt;
        end
        if (imem_ack) begin
          // Data is stale; newest target (including this cycle's) wins.
          fetch_addr_d = branch_valid ? w_branch_tgt : redirect_pc_q;
          state_d      = FETCH;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      fetch_addr_q  <= C_RESET_ADDR;
      redirect_pc_q <= 32'd0;
      instr_q       <= 32'd0;
      instr_pc_q    <= 32'd0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_addr_q  <= fetch_addr_d;
      redirect_pc_q <= redirect_pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // Request is a pure decode of the registered state.
  assign imem_req    = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_addr   = fetch_addr_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign pc_regs     = instr_pc_q + PC_READ_OFFSET;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. A behavioural memory acks
//            requests after a programmable latency; expected request
//            addresses and delivered instructions are queued by each
//            scenario and compared by a monitor on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc_regs;

  int checks;
  int errors;
  int mem_lat;
  int mem_budget;
  int mem_cnt;

  logic [31:0] req_q[$];
  exp_t        deliv_q[$];
  logic [31:0] mon_addr;
  exp_t        mon_exp;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clock        (clock),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .branch_valid (branch_valid),
    .branch_target(branch_target),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .pc_regs      (pc_regs)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_010C) return 32'hE3A0_1001;
    return a ^ 32'h5A5A_5A5A;
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.data = mem_word(pc);
    return e;
  endfunction

  // Behavioural instruction memory: acks after mem_lat cycles of request,
  // only while mem_budget allows.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    mem_cnt    = 0;
    forever begin
      @(posedge clock);
      #2;
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      if (reset || !imem_req) begin
        mem_cnt = 0;
      end else if (mem_budget > 0) begin
        mem_cnt++;
        if (mem_cnt >= mem_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          mem_cnt    = 0;
          mem_budget--;
        end
      end
    end
  end

  // Scoreboard monitor: pops expectations on completed reads and on
  // instructions accepted by decode.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (imem_req && imem_ack) begin
          checks++;
          if (req_q.size() == 0) begin
            errors++;
            $display("FAIL req_addr: ack at %h but no request expected", imem_addr);
          end else begin
            mon_addr = req_q.pop_front();
            if (imem_addr !== mon_addr) begin
              errors++;
              $display("FAIL req_addr: got %h expected %h", imem_addr, mon_addr);
            end
          end
        end
        if (instr_valid && instr_ready && !branch_valid) begin
          if (deliv_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL deliver: instr %h pc %h delivered, none expected", instr, instr_pc);
          end else begin
            mon_exp = deliv_q.pop_front();
            checks += 3;
            if (instr !== mon_exp.data) begin
              errors++;
              $display("FAIL deliver_instr: got %h expected %h", instr, mon_exp.data);
            end
            if (instr_pc !== mon_exp.pc) begin
              errors++;
              $display("FAIL deliver_pc: got %h expected %h", instr_pc, mon_exp.pc);
            end
            if (pc_regs !== mon_exp.pc + 32'd8) begin
              errors++;
              $display("FAIL deliver_pc_regs: got %h expected %h", pc_regs, mon_exp.pc + 32'd8);
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clock);
    #3;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    branch_valid  = 1'b0;
    branch_target = 32'd0;
    instr_ready   = 1'b1;
    mem_budget    = 0;
    mem_lat       = 1;
    cyc();
    cyc();
  endtask

  task automatic wait_queues(input int bound);
    int n = 0;
    while ((req_q.size() != 0 || deliv_q.size() != 0) && n < bound) begin
      cyc();
      n++;
    end
    checks++;
    if (req_q.size() != 0 || deliv_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: %0d requests and %0d instrs outstanding, expected 0",
               req_q.size(), deliv_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks += 7;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    if (imem_addr !== 32'h100) begin errors++; $display("FAIL reset_addr: got %h expected 00000100", imem_addr); end
    if (instr !== 32'd0) begin errors++; $display("FAIL reset_instr: got %h expected 0", instr); end
    if (instr_pc !== 32'd0) begin errors++; $display("FAIL reset_instr_pc: got %h expected 0", instr_pc); end
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    if (pc_regs !== 32'd8) begin errors++; $display("FAIL reset_pc_regs: got %h expected 8", pc_regs); end
    reset = 1'b0;
    #1;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %b expected 0", imem_req); end
  endtask

  task automatic test_stream();
    do_reset();
    mem_lat    = 1;
    mem_budget = 3;
    for (int k = 0; k < 3; k++) begin
      req_q.push_back(32'h100 + 32'(4 * k));
      deliv_q.push_back(mk_exp(32'h100 + 32'(4 * k)));
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      checks += 2;
      if (instr_valid !== ((i % 2) == 1)) begin
        errors++; $display("FAIL stream_valid[%0d]: got %b expected %b", i, instr_valid, (i % 2) == 1);
      end
      if (imem_req !== ((i % 2) == 0)) begin
        errors++; $display("FAIL stream_req[%0d]: got %b expected %b", i, imem_req, (i % 2) == 0);
      end
      if ((i % 2) == 0) begin
        checks++;
        if (imem_addr !== 32'h100 + 32'(2 * i)) begin
          errors++; $display("FAIL stream_addr[%0d]: got %h expected %h", i, imem_addr, 32'h100 + 32'(2 * i));
        end
      end
    end
    wait_queues(20);
  endtask

  // Continues from test_stream: fetch of 0x10C is pending with no ack yet.
  task automatic test_stall();
    int n = 0;
    instr_ready = 1'b0;
    req_q.push_back(32'h10C);
    deliv_q.push_back(mk_exp(32'h10C));
    mem_budget = 1;
    while (!instr_valid && n < 10) begin
      cyc();
      n++;
    end
    checks++;
    if (instr_valid !== 1'b1) begin
      errors++; $display("FAIL stall_valid_rise: got %b expected 1", instr_valid);
    end
    for (int i = 0; i < 5; i++) begin
      checks += 3;
      if (instr !== 32'hE3A0_1001) begin errors++; $display("FAIL stall_instr[%0d]: got %h expected e3a01001", i, instr); end
      if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, instr_valid); end
      if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d]: got %b expected 0", i, imem_req); end
      cyc();
    end
    instr_ready = 1'b1;
    req_q.push_back(32'h110);
    deliv_q.push_back(mk_exp(32'h110));
    mem_budget = 1;
    cyc();
    checks += 2;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL stall_next_req: got %b expected 1", imem_req); end
    if (imem_addr !== 32'h110) begin errors++; $display("FAIL stall_next_addr: got %h expected 00000110", imem_addr); end
    wait_queues(20);
  endtask

  task automatic test_drain();
    do_reset();
    mem_lat    = 3;
    mem_budget = 2;
    req_q.push_back(32'h100);
    req_q.push_back(32'h2000);
    deliv_q.push_back(mk_exp(32'h2000));
    reset = 1'b0;
    cyc();
    checks += 2;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL drain_req0: got %b expected 1", imem_req); end
    if (imem_addr !== 32'h100) begin errors++; $display("FAIL drain_addr0: got %h expected 00000100", imem_addr); end
    cyc();
    branch_valid  = 1'b1;
    branch_target = 32'h2003;
    cyc();
    branch_valid = 1'b0;
    checks += 2;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL drain_req1: got %b expected 1", imem_req); end
    if (imem_addr !== 32'h100) begin errors++; $display("FAIL drain_addr_stable: got %h expected 00000100", imem_addr); end
    cyc();
    checks += 2;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL drain_discard: got valid %b expected 0", instr_valid); end
    if (imem_addr !== 32'h2000) begin errors++; $display("FAIL drain_target: got %h expected 00002000", imem_addr); end
    wait_queues(20);
  endtask

  task automatic test_drain_latest();
    // Second branch coincides with the ack.
    do_reset();
    mem_lat    = 4;
    mem_budget = 2;
    req_q.push_back(32'h100);
    req_q.push_back(32'h4000);
    deliv_q.push_back(mk_exp(32'h4000));
    reset = 1'b0;
    cyc();
    branch_valid  = 1'b1;
    branch_target = 32'h3000;
    cyc();
    branch_valid = 1'b0;
    checks++;
    if (imem_addr !== 32'h100) begin errors++; $display("FAIL latest_addr_stable: got %h expected 00000100", imem_addr); end
    cyc();
    cyc();
    branch_valid  = 1'b1;
    branch_target = 32'h4000;
    cyc();
    branch_valid = 1'b0;
    checks += 2;
    if (imem_addr !== 32'h4000) begin errors++; $display("FAIL latest_same_cycle: got %h expected 00004000", imem_addr); end
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL latest_discard: got valid %b expected 0", instr_valid); end
    wait_queues(30);

    // Second branch arrives in DRAIN before the ack.
    do_reset();
    mem_lat    = 4;
    mem_budget = 2;
    req_q.push_back(32'h100);
    req_q.push_back(32'h5000);
    deliv_q.push_back(mk_exp(32'h5000));
    reset = 1'b0;
    cyc();
    branch_valid  = 1'b1;
    branch_target = 32'h3000;
    cyc();
    branch_target = 32'h5000;
    cyc();
    branch_valid = 1'b0;
    checks++;
    if (imem_addr !== 32'h100) begin errors++; $display("FAIL overwrite_addr_stable: got %h expected 00000100", imem_addr); end
    cyc();
    cyc();
    checks++;
    if (imem_addr !== 32'h5000) begin errors++; $display("FAIL overwrite_target: got %h expected 00005000", imem_addr); end
    wait_queues(30);
  endtask

  task automatic test_fetch_branch_ack();
    do_reset();
    mem_lat    = 1;
    mem_budget = 2;
    req_q.push_back(32'h100);
    req_q.push_back(32'h7000);
    deliv_q.push_back(mk_exp(32'h7000));
    reset = 1'b0;
    cyc();
    branch_valid  = 1'b1;
    branch_target = 32'h7000;
    cyc();
    branch_valid = 1'b0;
    checks += 3;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL fb_discard: got valid %b expected 0", instr_valid); end
    if (imem_req !== 1'b1) begin errors++; $display("FAIL fb_req: got %b expected 1", imem_req); end
    if (imem_addr !== 32'h7000) begin errors++; $display("FAIL fb_addr: got %h expected 00007000", imem_addr); end
    wait_queues(20);
  endtask

  task automatic test_hold_branch();
    do_reset();
    mem_lat    = 1;
    mem_budget = 1;
    req_q.push_back(32'h100);
    reset = 1'b0;
    cyc();
    cyc();
    checks++;
    if (instr_valid !== 1'b1) begin errors++; $display("FAIL hb_valid_before: got %b expected 1", instr_valid); end
    branch_valid  = 1'b1;
    branch_target = 32'h6000;
    instr_ready   = 1'b1;
    req_q.push_back(32'h6000);
    deliv_q.push_back(mk_exp(32'h6000));
    mem_budget = 1;
    cyc();
    branch_valid = 1'b0;
    checks += 3;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL hb_valid_drop: got %b expected 0", instr_valid); end
    if (imem_req !== 1'b1) begin errors++; $display("FAIL hb_req: got %b expected 1", imem_req); end
    if (imem_addr !== 32'h6000) begin errors++; $display("FAIL hb_addr: got %h expected 00006000", imem_addr); end
    wait_queues(20);
  endtask

  task automatic test_wrap();
    do_reset();
    mem_lat    = 1;
    mem_budget = 2;
    req_q.push_back(32'hFFFF_FFFC);
    req_q.push_back(32'h0);
    deliv_q.push_back(mk_exp(32'hFFFF_FFFC));
    deliv_q.push_back(mk_exp(32'h0));
    reset         = 1'b0;
    branch_valid  = 1'b1;
    branch_target = 32'hFFFF_FFFF;
    cyc();
    branch_valid = 1'b0;
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_idle_branch: got %h expected fffffffc", imem_addr); end
    cyc();
    checks += 2;
    if (instr_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid: got %b expected 1", instr_valid); end
    if (pc_regs !== 32'h4) begin errors++; $display("FAIL wrap_pc_regs: got %h expected 00000004", pc_regs); end
    cyc();
    checks += 2;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL wrap_req: got %b expected 1", imem_req); end
    if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h expected 00000000", imem_addr); end
    wait_queues(20);
  endtask

  task automatic test_async_reset();
    do_reset();
    mem_lat    = 1;
    mem_budget = 1;
    req_q.push_back(32'h100);
    deliv_q.push_back(mk_exp(32'h100));
    reset = 1'b0;
    wait_queues(20);
    mem_lat       = 4;
    mem_budget    = 1;
    branch_valid  = 1'b1;
    branch_target = 32'h8000;
    cyc();
    branch_valid = 1'b0;
    checks += 3;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL ar_drain_req: got %b expected 1", imem_req); end
    if (imem_addr !== 32'h104) begin errors++; $display("FAIL ar_drain_addr: got %h expected 00000104", imem_addr); end
    if (instr_pc !== 32'h100) begin errors++; $display("FAIL ar_pre_pc: got %h expected 00000100", instr_pc); end
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    checks += 6;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL ar_req: got %b expected 0", imem_req); end
    if (imem_addr !== 32'h100) begin errors++; $display("FAIL ar_addr: got %h expected 00000100", imem_addr); end
    if (instr !== 32'd0) begin errors++; $display("FAIL ar_instr: got %h expected 0", instr); end
    if (instr_pc !== 32'd0) begin errors++; $display("FAIL ar_instr_pc: got %h expected 0", instr_pc); end
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b expected 0", instr_valid); end
    if (pc_regs !== 32'd8) begin errors++; $display("FAIL ar_pc_regs: got %h expected 8", pc_regs); end
    mem_budget = 0;
    cyc();
    cyc();
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    branch_valid  = 1'b0;
    branch_target = 32'd0;
    instr_ready   = 1'b1;
    mem_lat       = 1;
    mem_budget    = 0;

    test_reset();
    test_stream();
    test_stall();
    test_drain();
    test_drain_latest();
    test_fetch_branch_ack();
    test_hold_branch();
    test_wrap();
    test_async_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the register file. Owns the fetch address and issues word reads to instruction memory over a req/ack handshake. Buffers one fetched instruction for decode under a valid/ready handshake and handles branch redirects, including discarding an in-flight read. Drives the r15 value (`pc_regs`) that the register file writes every rising edge.

## Interface
- `RESET_PC`, 32'h0000_0000: fetch address after reset. Bits [1:0] are ignored and treated as 0.
- `clock` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `imem_req` out 1: read request. Held high until `imem_ack`.
- `imem_addr` out 32: word-aligned read address. Stable while `imem_req` is high.
- `imem_ack` in 1: one-cycle completion pulse. May arrive in the same cycle `imem_req` rises.
- `imem_rdata` in 32: instruction word. Valid only when `imem_ack` is high.
- `branch_valid` in 1: one-cycle redirect strobe from execute.
- `branch_target` in 32: redirect address. Bits [1:0] are forced to 0.
- `instr` out 32: buffered instruction.
- `instr_pc` out 32: address of `instr`.
- `instr_valid` out 1: buffer holds an instruction.
- `instr_ready` in 1: decode accepts `instr` this cycle.
- `pc_regs` out 32: `instr_pc + 8` mod 2^32 (ARM PC read offset). Drives the register file `pc_in`.

## Operation
- States: IDLE, FETCH, HOLD, DRAIN.
- Internal registers: `fetch_addr` drives `imem_addr`; `redirect_pc` holds a pending branch target.
- `imem_req` is a decode of state: it is 1 in FETCH and DRAIN, 0 otherwise.
- **IDLE** (reset state) -> FETCH on the next edge.
  - If `branch_valid` is high, `fetch_addr <= branch_target`.
- **FETCH**:
  - On `imem_ack` with no branch: `instr <= imem_rdata`, `instr_pc <= fetch_addr`, `instr_valid <= 1`, `fetch_addr <= fetch_addr + 4` (wraps 0xFFFF_FFFC -> 0). Go to HOLD.
  - On `branch_valid` with `imem_ack` in the same cycle: discard `imem_rdata`, `fetch_addr <= target`, stay in FETCH.
  - On `branch_valid` without `imem_ack`: `redirect_pc <= target`, go to DRAIN. `fetch_addr` is unchanged so the address stays stable.
- **HOLD**:
  - `branch_valid` has priority: `instr_valid <= 0`, `fetch_addr <= target`, go to FETCH.
  - Else on `instr_ready`: `instr_valid <= 0`, go to FETCH.
- **DRAIN**: `imem_req` stays high with the old address.
  - A new `branch_valid` overwrites `redirect_pc`; the latest target wins.
  - On `imem_ack`: discard the data, `fetch_addr <=` the newest target (including a same-cycle branch), go to FETCH.
- `instr_valid` is never set outside FETCH, so the buffer is always empty when a response is accepted.
- `instr` and `instr_pc` hold their values when `instr_valid` drops.
- `imem_ack` outside FETCH/DRAIN is a protocol error and is ignored.

## Timing
- Reset (asynchronous, immediate): state IDLE, `fetch_addr = RESET_PC & ~3`, `redirect_pc = 0`, `instr = 0`, `instr_pc = 0`, `instr_valid = 0`, `imem_req = 0`, `pc_regs = 8`.
- First `imem_req` is high in the first cycle after reset deasserts plus one edge (IDLE -> FETCH).
- Latency: with a same-cycle ack, `instr_valid` rises on the edge after `imem_req` rises.
- Peak throughput is 1 instruction per 2 cycles: FETCH/ack, then HOLD/ready.
- `pc_regs` updates on the same edge as `instr_pc`.
- Branch-to-first-request: 1 cycle from FETCH-with-ack or from HOLD. From DRAIN it is the ack cycle plus 1.
- Reset mid-transaction: the outstanding request is abandoned. Memory must tolerate `imem_req` dropping without an ack.

## Structure
- Shared package `fetch_pkg`:
  - state enum `fetch_state_t` {IDLE, FETCH, HOLD, DRAIN}
  - `PC_STEP = 4`
  - `PC_READ_OFFSET = 8`
  - `WORD_MASK = 32'hFFFF_FFFC`
- Single module with no sub-modules. Next-state/output logic is one combinational block; registers are in one sequential block with async reset.

## Test plan
- Reset with `RESET_PC = 0x100`, memory acking same-cycle, `instr_ready = 1`: `imem_addr` sequence is 0x100, 0x104, 0x108. `instr_pc` matches each address, `pc_regs` = 0x108, 0x10C, 0x110, and `instr_valid` pulses every 2 cycles.
- Decode stalls (`instr_ready = 0`) for 5 cycles with `instr = 0xE3A01001`: `instr` and `instr_valid` hold and `imem_req = 0` throughout. After ready, the next request is to `instr_pc + 4`.
- Memory with 3-cycle ack latency; branch to 0x2003 in the second wait cycle: state goes to DRAIN, `imem_addr` is unchanged until the ack, and the data is discarded (`instr_valid` stays 0). The next request goes to 0x2000.
- Two branches during DRAIN (0x3000, then 0x4000), the second coinciding with the ack: the next request goes to 0x4000.
- `fetch_addr = 0xFFFF_FFFC` fetched and accepted: the next request goes to 0x0000_0000, and `pc_regs` = 0x0000_0004.
- Branch in HOLD together with `instr_ready = 1`: `instr_valid` drops and the next request goes to the target. Asynchronous reset asserted while in DRAIN: all outputs return to reset values without waiting for a clock edge.
